// File: rtl/i2cs_arb_pkg.sv
// Shared types and defaults for the i2cs register-bank write arbiter.
package i2cs_arb_pkg;

  localparam int unsigned ARB_ADDR_WID = 8;
  localparam int unsigned ARB_DATA_WID = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MST  = 2'd1,
    ST_SLV  = 2'd2
  } arb_state_e;

  // Skid entry at the default register-bank widths.
  typedef struct packed {
    logic [ARB_ADDR_WID-1:0] addr;
    logic [ARB_DATA_WID-1:0] data;
  } skid_entry_t;

endpackage

// File: rtl/i2cs_skid_fifo.sv
// Synchronous power-of-2 deep FIFO buffering the un-throttled master write stream.
module i2cs_skid_fifo
  import i2cs_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                       i2cs_clk,
  input  logic                       i2cs_rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem_q[rd_ptr_q];

  // A push into a full queue is only accepted when the head leaves the same cycle.
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    cnt_d    = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge i2cs_clk or negedge i2cs_rst_n) begin
    if (!i2cs_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge i2cs_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/i2cs_regwr_arb.sv
// Register-bank write-port arbiter: skid-buffered master stream vs. req/ack slave core.
// Optional statistics counters enabled by defining I2CS_ARB_STAT_EN.
module i2cs_regwr_arb
  import i2cs_arb_pkg::*;
#(
  parameter int unsigned SKID_DEPTH = 4,
  parameter int unsigned ADDR_WID   = ARB_ADDR_WID,
  parameter int unsigned DATA_WID   = ARB_DATA_WID,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                          i2cs_clk,
  input  logic                          i2cs_rst_n,
  input  logic                          i_mst_wr_en,
  input  logic [ADDR_WID-1:0]           i_mst_wr_addr,
  input  logic [DATA_WID-1:0]           i_mst_wr_data,
  input  logic                          i_slv_wr_req,
  input  logic [ADDR_WID-1:0]           i_slv_wr_addr,
  input  logic [DATA_WID-1:0]           i_slv_wr_data,
  output logic                          o_slv_wr_ack,
  input  logic                          i_reg_busy,
  output logic                          o_reg_wr_en,
  output logic [ADDR_WID-1:0]           o_reg_wr_addr,
  output logic [DATA_WID-1:0]           o_reg_wr_data,
  output logic                          o_mst_ovf,
  input  logic                          i_ovf_clr,
  output logic [$clog2(SKID_DEPTH):0]   o_skid_cnt
`ifdef I2CS_ARB_STAT_EN
  ,
  output logic [7:0]                    o_mst_drop_cnt,
  output logic [7:0]                    o_slv_wait_cnt
`endif
);

  localparam int unsigned CNT_W    = $clog2(SKID_DEPTH) + 1;
  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [ADDR_WID-1:0] addr;
    logic [DATA_WID-1:0] data;
  } entry_t;

  arb_state_e           state_q, state_d;
  logic [STARVE_W-1:0]  starve_q, starve_d;
  logic [ADDR_WID-1:0]  addr_q, addr_d;
  logic [DATA_WID-1:0]  data_q, data_d;
  logic                 ovf_q, ovf_d;

  entry_t               push_ent, head_ent;
  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]     fifo_cnt;
  logic                 slv_req, mst_drop;

  assign push_ent = '{addr: i_mst_wr_addr, data: i_mst_wr_data};

  i2cs_skid_fifo #(
    .DEPTH (SKID_DEPTH),
    .WIDTH (ADDR_WID + DATA_WID)
  ) u_skid (
    .i2cs_clk   (i2cs_clk),
    .i2cs_rst_n (i2cs_rst_n),
    .push       (i_mst_wr_en),
    .pop        (fifo_pop),
    .din        (push_ent),
    .dout       (head_ent),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_cnt)
  );

  // The ack cycle still sees the request high; masking it prevents a second grant.
  assign slv_req  = i_slv_wr_req && (state_q != ST_SLV);
  assign mst_drop = i_mst_wr_en && fifo_full && !fifo_pop;

  always_comb begin
    state_d  = ST_IDLE;
    starve_d = starve_q;
    fifo_pop = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    if (!i_reg_busy) begin
      if (!fifo_empty && (!slv_req || starve_q < STARVE_W'(STARVE_MAX))) begin
        state_d  = ST_MST;
        fifo_pop = 1'b1;
        starve_d = slv_req ? starve_q + STARVE_W'(1) : '0;
        addr_d   = head_ent.addr;
        data_d   = head_ent.data;
      end else if (slv_req) begin
        state_d  = ST_SLV;
        starve_d = '0;
        addr_d   = i_slv_wr_addr;
        data_d   = i_slv_wr_data;
      end
    end
    ovf_d = ovf_q;
    if (mst_drop)       ovf_d = 1'b1;
    else if (i_ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge i2cs_clk or negedge i2cs_rst_n) begin
    if (!i2cs_rst_n) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
    end
  end

  // The registered state doubles as the issued-write indication.
  assign o_reg_wr_en   = (state_q != ST_IDLE);
  assign o_slv_wr_ack  = (state_q == ST_SLV);
  assign o_reg_wr_addr = addr_q;
  assign o_reg_wr_data = data_q;
  assign o_mst_ovf     = ovf_q;
  assign o_skid_cnt    = fifo_cnt;

`ifdef I2CS_ARB_STAT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    wait_cnt_d = wait_cnt_q;
    if (i_ovf_clr) begin
      drop_cnt_d = '0;
      wait_cnt_d = '0;
    end else begin
      if (mst_drop && drop_cnt_q != '1)                   drop_cnt_d = drop_cnt_q + 8'd1;
      if (slv_req && state_d != ST_SLV && wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i2cs_clk or negedge i2cs_rst_n) begin
    if (!i2cs_rst_n) begin
      drop_cnt_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign o_mst_drop_cnt = drop_cnt_q;
  assign o_slv_wait_cnt = wait_cnt_q;
`endif

endmodule

// File: tb/tb_i2cs_regwr_arb.sv
// Self-checking bench for i2cs_regwr_arb: queue-based reference model plus directed literal checks.
module tb_i2cs_regwr_arb;

  logic       clk;
  logic       rst_n;
  logic       mst_en;
  logic [7:0] mst_addr, mst_data;
  logic       slv_req;
  logic [7:0] slv_addr, slv_data;
  logic       slv_ack;
  logic       busy;
  logic       wr_en;
  logic [7:0] wr_addr, wr_data;
  logic       ovf;
  logic       ovf_clr;
  logic [2:0] skid_cnt;
`ifdef I2CS_ARB_STAT_EN
  logic [7:0] drop_cnt, wait_cnt;
`endif

  i2cs_regwr_arb #(
    .SKID_DEPTH (4),
    .ADDR_WID   (8),
    .DATA_WID   (8),
    .STARVE_MAX (3)
  ) dut (
    .i2cs_clk      (clk),
    .i2cs_rst_n    (rst_n),
    .i_mst_wr_en   (mst_en),
    .i_mst_wr_addr (mst_addr),
    .i_mst_wr_data (mst_data),
    .i_slv_wr_req  (slv_req),
    .i_slv_wr_addr (slv_addr),
    .i_slv_wr_data (slv_data),
    .o_slv_wr_ack  (slv_ack),
    .i_reg_busy    (busy),
    .o_reg_wr_en   (wr_en),
    .o_reg_wr_addr (wr_addr),
    .o_reg_wr_data (wr_data),
    .o_mst_ovf     (ovf),
    .i_ovf_clr     (ovf_clr),
    .o_skid_cnt    (skid_cnt)
`ifdef I2CS_ARB_STAT_EN
    ,
    .o_mst_drop_cnt (drop_cnt),
    .o_slv_wait_cnt (wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: arrival-ordered queue of beats, arbitration rules applied per edge.
  logic [15:0] mq[$];
  bit          m_en, m_ack, m_ovf;
  logic [7:0]  m_addr, m_data;
  int          m_starve;

  task automatic model_reset();
    mq.delete();
    m_en = 0; m_ack = 0; m_ovf = 0;
    m_addr = '0; m_data = '0; m_starve = 0;
  endtask

  task automatic model_step();
    bit eff = slv_req && !m_ack;
    bit n_en = 0, n_ack = 0, drop = 0;
    logic [15:0] e;
    if (!busy) begin
      if (mq.size() > 0 && (!eff || m_starve < 3)) begin
        e = mq.pop_front();
        n_en = 1;
        {m_addr, m_data} = e;
        m_starve = eff ? m_starve + 1 : 0;
      end else if (eff) begin
        n_en = 1; n_ack = 1;
        m_addr = slv_addr; m_data = slv_data;
        m_starve = 0;
      end
    end
    if (mst_en) begin
      if (mq.size() < 4) mq.push_back({mst_addr, mst_data});
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    m_en = n_en; m_ack = n_ack;
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      check("wr_en",   32'(wr_en),    32'(m_en));
      check("ack",     32'(slv_ack),  32'(m_ack));
      check("addr",    32'(wr_addr),  32'(m_addr));
      check("data",    32'(wr_data),  32'(m_data));
      check("ovf",     32'(ovf),      32'(m_ovf));
      check("skid_cnt", 32'(skid_cnt), 32'(mq.size()));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  logic [8:0] wlog[$];
  task automatic tick_log();
    tick();
    if (wr_en) wlog.push_back({slv_ack, wr_addr});
  endtask

  bit ack_seen;

  initial begin
    rst_n = 1; mst_en = 0; mst_addr = '0; mst_data = '0;
    slv_req = 0; slv_addr = '0; slv_data = '0; busy = 0; ovf_clr = 0;
    model_reset();
    #2 rst_n = 0;
    #1;
    check("rst_en",   32'(wr_en), 0);
    check("rst_ack",  32'(slv_ack), 0);
    check("rst_addr", 32'(wr_addr), 0);
    check("rst_data", 32'(wr_data), 0);
    check("rst_ovf",  32'(ovf), 0);
    check("rst_cnt",  32'(skid_cnt), 0);
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1;
    chk_on = 1;
    tick(); tick();

    // Single master beat: issued two edges after it is presented.
    mst_en = 1; mst_addr = 8'h10; mst_data = 8'hA5;
    tick();
    mst_en = 0;
    check("t1_en_early", 32'(wr_en), 0);
    check("t1_cnt1",     32'(skid_cnt), 1);
    tick();
    check("t1_en",   32'(wr_en), 1);
    check("t1_addr", 32'(wr_addr), 32'h10);
    check("t1_data", 32'(wr_data), 32'hA5);
    check("t1_cnt0", 32'(skid_cnt), 0);
    tick();
    check("t1_en_after", 32'(wr_en), 0);

    // Lone slave request: ack one edge later, for one cycle despite req still high.
    slv_req = 1; slv_addr = 8'h20; slv_data = 8'h3C;
    tick();
    check("t2_en",   32'(wr_en), 1);
    check("t2_ack",  32'(slv_ack), 1);
    check("t2_addr", 32'(wr_addr), 32'h20);
    check("t2_data", 32'(wr_data), 32'h3C);
    tick();
    slv_req = 0;
    check("t2_en_once",  32'(wr_en), 0);
    check("t2_ack_once", 32'(slv_ack), 0);
    check("t2_addr_hold", 32'(wr_addr), 32'h20);
    tick();

    // Starvation limit: slave waits behind at most three master writes.
    wlog.delete();
    ack_seen = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      mst_en = 1; mst_addr = 8'(8'h40 + i); mst_data = 8'(8'h80 + i);
      if (i == 1) begin slv_req = 1; slv_addr = 8'h55; slv_data = 8'h66; end
      tick_log();
      if (ack_seen) slv_req = 0;
      ack_seen = slv_ack;
    end
    mst_en = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      tick_log();
      if (ack_seen) slv_req = 0;
      ack_seen = slv_ack;
    end
    slv_req = 0;
    check("t3_nwr", 32'(wlog.size()), 11);
    check("t3_w0", 32'(wlog[0]), 32'h040);
    check("t3_w1", 32'(wlog[1]), 32'h041);
    check("t3_w2", 32'(wlog[2]), 32'h042);
    check("t3_w3", 32'(wlog[3]), 32'h155);
    check("t3_w4", 32'(wlog[4]), 32'h043);
    check("t3_w10", 32'(wlog[10]), 32'h049);

    // Busy for 10 cycles while 6 beats arrive: 4 kept, 2 dropped.
    wlog.delete();
    busy = 1;
    for (int unsigned i = 0; i < 10; i++) begin
      mst_en = (i < 6); mst_addr = 8'(8'h60 + i); mst_data = 8'(8'hC0 + i);
      tick_log();
    end
    mst_en = 0;
    check("t4_ovf",   32'(ovf), 1);
    check("t4_cnt",   32'(skid_cnt), 4);
    check("t4_nobusywr", 32'(wlog.size()), 0);
    busy = 0;
    for (int unsigned i = 0; i < 8; i++) tick_log();
    check("t4_nwr", 32'(wlog.size()), 4);
    for (int unsigned i = 0; i < 4; i++) check("t4_order", 32'(wlog[i]), 32'(8'h60 + i));

    // Overflow flag clear/set priority, and push+pop on a full queue.
    ovf_clr = 1; tick(); ovf_clr = 0;
    check("t5_clr", 32'(ovf), 0);
    busy = 1;
    for (int unsigned i = 0; i < 4; i++) begin
      mst_en = 1; mst_addr = 8'(8'h70 + i); mst_data = 8'(i);
      tick();
    end
    check("t5_full", 32'(skid_cnt), 4);
    busy = 0; mst_addr = 8'h74; mst_data = 8'h04;
    tick();
    check("t5_pp_cnt",  32'(skid_cnt), 4);
    check("t5_pp_ovf",  32'(ovf), 0);
    check("t5_pp_addr", 32'(wr_addr), 32'h70);
    busy = 1; mst_addr = 8'h75; mst_data = 8'h05; ovf_clr = 1;
    tick();
    check("t5_drop_clr", 32'(ovf), 1);
    mst_en = 0;
    tick();
    ovf_clr = 0;
    check("t5_clr2", 32'(ovf), 0);
    busy = 0;
    for (int unsigned i = 0; i < 6; i++) tick();

    // Reset with beats queued and slave waiting: only the slave write survives.
    busy = 1;
    for (int unsigned i = 0; i < 3; i++) begin
      mst_en = 1; mst_addr = 8'(8'h80 + i); mst_data = 8'(8'h10 + i);
      tick();
    end
    mst_en = 0;
    slv_req = 1; slv_addr = 8'h90; slv_data = 8'h91;
    tick();
    check("t6_pre_cnt", 32'(skid_cnt), 3);
    #1 rst_n = 0;
    model_reset();
    #1;
    check("t6_rst_en",   32'(wr_en), 0);
    check("t6_rst_ack",  32'(slv_ack), 0);
    check("t6_rst_addr", 32'(wr_addr), 0);
    check("t6_rst_data", 32'(wr_data), 0);
    check("t6_rst_ovf",  32'(ovf), 0);
    check("t6_rst_cnt",  32'(skid_cnt), 0);
    busy = 0;
    @(posedge clk);
    #3 rst_n = 1;
    wlog.delete();
    tick_log();
    check("t6_ack",  32'(slv_ack), 1);
    check("t6_addr", 32'(wr_addr), 32'h90);
    check("t6_data", 32'(wr_data), 32'h91);
    tick_log();
    slv_req = 0;
    for (int unsigned i = 0; i < 4; i++) tick_log();
    check("t6_nwr", 32'(wlog.size()), 1);

    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i2cs_regwr_arb.md
Name: i2cs_regwr_arb

Overview:
Write-port arbiter for the slave-side register bank in the i2cs_clk domain. Two requesters share the single write port: the master write stream drained from the async CDC FIFO, and the local I2C slave core.
- The master stream has no backpressure: the FIFO pops whenever it is non-empty. The block therefore buffers it in a small skid queue.
- The slave core is served by a req/ack handshake.

Parameters:
SKID_DEPTH, 4, entries in master skid queue (power of 2, >=2)
ADDR_WID, 8, register address width
DATA_WID, 8, register data width
STARVE_MAX, 3, max consecutive master grants while a slave request is pending

Ports:
i2cs_clk  in  1  register-bank clock
i2cs_rst_n  in  1  async active-low reset
i_mst_wr_en  in  1  master write strobe from CDC FIFO (one beat per cycle)
i_mst_wr_addr  in  ADDR_WID  master write address
i_mst_wr_data  in  DATA_WID  master write data
i_slv_wr_req  in  1  slave core write request (level, held until ack)
i_slv_wr_addr  in  ADDR_WID  slave write address
i_slv_wr_data  in  DATA_WID  slave write data
o_slv_wr_ack  out  1  one-cycle ack; slave write issued this cycle
i_reg_busy  in  1  register bank cannot accept a write this cycle
o_reg_wr_en  out  1  register write strobe
o_reg_wr_addr  out  ADDR_WID  register write address
o_reg_wr_data  out  DATA_WID  register write data
o_mst_ovf  out  1  sticky: a master beat was dropped
i_ovf_clr  in  1  clears o_mst_ovf
o_skid_cnt  out  $clog2(SKID_DEPTH)+1  current skid occupancy

Behaviour:
- Reset (async, i2cs_rst_n=0):
  - skid queue empty; starve counter 0; state IDLE.
  - o_reg_wr_en=0, o_reg_wr_addr=0, o_reg_wr_data=0, o_slv_wr_ack=0, o_mst_ovf=0, o_skid_cnt=0.
- Skid queue:
  - Push on i_mst_wr_en.
  - Push when full with no pop in the same cycle: beat dropped, o_mst_ovf set.
  - Push and pop in the same cycle on a full queue: legal, no drop.
  - Pointers wrap modulo SKID_DEPTH.
- FSM states:
  - IDLE: no grant.
  - MST: head of skid popped.
  - SLV: slave request served.
- Decision each cycle, when i_reg_busy=0:
  - If skid non-empty and (no slave req, or starve<STARVE_MAX): next=MST. Starve counter increments if a slave req is pending, else resets to 0.
  - Else if slave req pending: next=SLV, starve counter reset to 0.
  - Else: next=IDLE.
- i_reg_busy=1: next=IDLE; no pop, no ack; starve counter holds.
- Outputs are registered, issued the cycle after the grant decision:
  - MST: o_reg_wr_en=1 with the popped entry.
  - SLV: o_reg_wr_en=1 and o_slv_wr_ack=1 with the slave addr/data.
  - IDLE: o_reg_wr_en=0; addr/data hold their last values.
- Latency:
  - Master beat to o_reg_wr_en: 2 cycles minimum (push edge, then decide, then issue).
  - Slave req to ack: 1 cycle minimum.
- Slave handshake:
  - The slave core must drop i_slv_wr_req in the cycle after the ack.
  - The arbiter ignores the req in the cycle directly following an ack, so the same request is never double-granted.
- Same-address writes:
  - No merging; every write is issued in grant order.
  - Master beats stay strictly in order.
- o_mst_ovf:
  - i_ovf_clr has priority over a set in the same cycle, except when a drop occurs that cycle: then the flag stays set.
- Reset mid-operation: queued beats are discarded; a held slave request is re-arbitrated after reset release.

Optional Feature:
I2CS_ARB_STAT_EN
- Defined: adds outputs o_mst_drop_cnt [7:0] and o_slv_wait_cnt [7:0].
  - o_mst_drop_cnt: saturating count of dropped master beats.
  - o_slv_wait_cnt: saturating count of cycles a slave req waited un-acked.
  - Both reset to 0 and clear on i_ovf_clr.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package i2cs_arb_pkg holds:
  - FSM state enum (IDLE/MST/SLV);
  - default ADDR_WID/DATA_WID constants;
  - a skid entry struct {addr, data}.
- One sub-module: i2cs_skid_fifo, a synchronous SKID_DEPTH-deep FIFO with push/pop/full/empty/count.

Test Plan:
- Reset, then a single master beat addr=0x10 data=0xA5 -> o_reg_wr_en=1 exactly 2 cycles later with 0x10/0xA5; o_skid_cnt returns to 0.
- Lone slave req addr=0x20 data=0x3C -> o_reg_wr_en and o_slv_wr_ack both high 1 cycle later, for exactly 1 cycle.
- Master beats every cycle with slave req held, STARVE_MAX=3 -> 3 master writes, then the slave write, then master writes resume; master order preserved.
- i_reg_busy=1 for 10 cycles while 6 master beats arrive (SKID_DEPTH=4) -> first 4 kept, 2 dropped, o_mst_ovf=1; after release exactly 4 writes come out in order.
- Drop in the same cycle as i_ovf_clr -> o_mst_ovf stays 1; i_ovf_clr on a later cycle -> 0.
- Assert reset with 3 beats queued and slave req pending -> all outputs 0 immediately; after release, only the slave write is issued (1 cycle after re-arbitration).
